// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/operand-select encodings and
// the D/E pipeline register layout.
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        A_RD1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } alu_a_src_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        result_src_e result_src;
        alu_a_src_e  alu_a_src;
        logic        alu_b_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
        logic        illegal;
    } de_ex_t;

    // Only register-register ops may turn funct7[5] into SUB; shifts use it for SRA either way.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_b5,
                                           input logic       is_reg_op);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg_op && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stage_instruction_decode_if.sv
// Fetch, writeback and D/E pipeline-register signals of the decode stage.
interface stage_instruction_decode_if;
    logic [31:0] de_instr;
    logic [31:0] de_pc;
    logic [31:0] de_pc_plus4;
    logic        ex_flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] ex_pc_plus4;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_jalr;
    logic [1:0]  ex_result_src;
    logic [1:0]  ex_alu_a_src;
    logic        ex_alu_b_src;
    logic [3:0]  ex_alu_ctrl;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    modport master (
        input  de_instr, de_pc, de_pc_plus4, ex_flush, wb_reg_write, wb_rd, wb_result,
        output de_rs1, de_rs2, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_pc,
               ex_pc_plus4, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr,
               ex_result_src, ex_alu_a_src, ex_alu_b_src, ex_alu_ctrl, ex_funct3, ex_illegal
    );

    modport slave (
        output de_instr, de_pc, de_pc_plus4, ex_flush, wb_reg_write, wb_rd, wb_result,
        input  de_rs1, de_rs2, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_pc,
               ex_pc_plus4, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr,
               ex_result_src, ex_alu_a_src, ex_alu_b_src, ex_alu_ctrl, ex_funct3, ex_illegal
    );
endinterface

// File: rtl/register_file.sv
// 31 x 32-bit architectural registers: two combinational reads, one write,
// x0 hard-wired to zero and write-through bypass to the read ports.
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != 5'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A same-cycle writeback wins over the stored value so decode never reads stale data.
    assign rs1_data = (rs1_addr == 5'd0)                  ? 32'd0   :
                      (wr_en && (wr_addr == rs1_addr))    ? wr_data : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                  ? 32'd0   :
                      (wr_en && (wr_addr == rs2_addr))    ? wr_data : regs_q[rs2_addr];

endmodule

// File: rtl/stage_instruction_decode.sv
// RV32I decode stage: control decode, immediate generation, register read and
// the D/E pipeline register.
module stage_instruction_decode
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                         clk,
    input logic                         rst_n,
    stage_instruction_decode_if.master  bus
);
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] imm;

    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    result_src_e result_src;
    alu_a_src_e  alu_a_src;
    logic        alu_b_src;
    alu_op_e     alu_ctrl;
    logic        illegal;
    imm_type_e   imm_type;

    de_ex_t de_ex_d;
    de_ex_t de_ex_q;

    assign instr  = bus.de_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.de_rs1 = rs1;
    assign bus.de_rs2 = rs2;

    register_file u_register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rf_rd1),
        .rs2_data (rf_rd2),
        .wr_en    (bus.wb_reg_write),
        .wr_addr  (bus.wb_rd),
        .wr_data  (bus.wb_result)
    );

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        result_src = RES_ALU;
        alu_a_src  = A_RD1;
        alu_b_src  = 1'b0;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        imm_type   = IMM_I;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_decode(funct3, instr[30], 1'b1);
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                alu_b_src = 1'b1;
                alu_ctrl  = alu_decode(funct3, instr[30], 1'b0);
            end
            OPC_LOAD: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                alu_b_src  = 1'b1;
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                alu_b_src = 1'b1;
                imm_type  = IMM_S;
            end
            OPC_BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm_type = IMM_B;
            end
            OPC_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                alu_a_src  = A_PC;
                alu_b_src  = 1'b1;
                imm_type   = IMM_J;
            end
            OPC_JALR: begin
                jump       = 1'b1;
                jalr       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                alu_b_src  = 1'b1;
            end
            OPC_LUI: begin
                reg_write = 1'b1;
                alu_a_src = A_ZERO;
                alu_b_src = 1'b1;
                imm_type  = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                alu_a_src = A_PC;
                alu_b_src = 1'b1;
                imm_type  = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (imm_type)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    // A flush loads the all-zero record, which is the NOP bubble.
    always_comb begin
        de_ex_d = '0;
        if (!bus.ex_flush) begin
            de_ex_d.rd1        = rf_rd1;
            de_ex_d.rd2        = rf_rd2;
            de_ex_d.imm        = imm;
            de_ex_d.rs1        = rs1;
            de_ex_d.rs2        = rs2;
            de_ex_d.rd         = rd;
            de_ex_d.pc         = bus.de_pc;
            de_ex_d.pc_plus4   = bus.de_pc_plus4;
            de_ex_d.reg_write  = reg_write;
            de_ex_d.mem_write  = mem_write;
            de_ex_d.branch     = branch;
            de_ex_d.jump       = jump;
            de_ex_d.jalr       = jalr;
            de_ex_d.result_src = result_src;
            de_ex_d.alu_a_src  = alu_a_src;
            de_ex_d.alu_b_src  = alu_b_src;
            de_ex_d.alu_ctrl   = alu_ctrl;
            de_ex_d.funct3     = funct3;
            de_ex_d.illegal    = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_ex_q          <= '0;
            de_ex_q.pc       <= RESET_PC;
            de_ex_q.pc_plus4 <= RESET_PC + 32'd4;
        end else begin
            de_ex_q <= de_ex_d;
        end
    end

    assign bus.ex_rd1        = de_ex_q.rd1;
    assign bus.ex_rd2        = de_ex_q.rd2;
    assign bus.ex_imm        = de_ex_q.imm;
    assign bus.ex_rs1        = de_ex_q.rs1;
    assign bus.ex_rs2        = de_ex_q.rs2;
    assign bus.ex_rd         = de_ex_q.rd;
    assign bus.ex_pc         = de_ex_q.pc;
    assign bus.ex_pc_plus4   = de_ex_q.pc_plus4;
    assign bus.ex_reg_write  = de_ex_q.reg_write;
    assign bus.ex_mem_write  = de_ex_q.mem_write;
    assign bus.ex_branch     = de_ex_q.branch;
    assign bus.ex_jump       = de_ex_q.jump;
    assign bus.ex_jalr       = de_ex_q.jalr;
    assign bus.ex_result_src = de_ex_q.result_src;
    assign bus.ex_alu_a_src  = de_ex_q.alu_a_src;
    assign bus.ex_alu_b_src  = de_ex_q.alu_b_src;
    assign bus.ex_alu_ctrl   = de_ex_q.alu_ctrl;
    assign bus.ex_funct3     = de_ex_q.funct3;
    assign bus.ex_illegal    = de_ex_q.illegal;

endmodule

// File: tb/tb_stage_instruction_decode.sv
// Table-driven bench for the decode stage with an expected-value queue and a
// small register-file model for operand expectations.
module tb_stage_instruction_decode;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        mw;
        logic        br;
        logic        jp;
        logic        jr;
        logic [1:0]  res;
        logic [1:0]  as;
        logic        bs;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        mw;
        logic        br;
        logic        jp;
        logic        jr;
        logic [1:0]  res;
        logic [1:0]  as;
        logic        bs;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] ref_regs [0:31];
    exp_t sb[$];
    vec_t vecs[15];

    stage_instruction_decode_if bus ();

    stage_instruction_decode #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    task automatic check_output(input exp_t e, input string tag);
        chk(tag, "imm",        bus.ex_imm,                e.imm);
        chk(tag, "rd1",        bus.ex_rd1,                e.rd1);
        chk(tag, "rd2",        bus.ex_rd2,                e.rd2);
        chk(tag, "pc",         bus.ex_pc,                 e.pc);
        chk(tag, "pc_plus4",   bus.ex_pc_plus4,           e.pc4);
        chk(tag, "rd",         32'(bus.ex_rd),            32'(e.rd));
        chk(tag, "rs1",        32'(bus.ex_rs1),           32'(e.rs1));
        chk(tag, "rs2",        32'(bus.ex_rs2),           32'(e.rs2));
        chk(tag, "reg_write",  32'(bus.ex_reg_write),     32'(e.rw));
        chk(tag, "mem_write",  32'(bus.ex_mem_write),     32'(e.mw));
        chk(tag, "branch",     32'(bus.ex_branch),        32'(e.br));
        chk(tag, "jump",       32'(bus.ex_jump),          32'(e.jp));
        chk(tag, "jalr",       32'(bus.ex_jalr),          32'(e.jr));
        chk(tag, "result_src", 32'(bus.ex_result_src),    32'(e.res));
        chk(tag, "alu_a_src",  32'(bus.ex_alu_a_src),     32'(e.as));
        chk(tag, "alu_b_src",  32'(bus.ex_alu_b_src),     32'(e.bs));
        chk(tag, "alu_ctrl",   32'(bus.ex_alu_ctrl),      32'(e.alu));
        chk(tag, "funct3",     32'(bus.ex_funct3),        32'(e.f3));
        chk(tag, "illegal",    32'(bus.ex_illegal),       32'(e.ill));
    endtask

    function automatic exp_t reset_expect();
        exp_t e;
        e = '{default: '0};
        e.pc  = RST_PC;
        e.pc4 = RST_PC + 32'd4;
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs, input vec_t v);
        if (rs == 5'd0) return 32'd0;
        if (v.wb_we && (v.wb_rd == rs)) return v.wb_data;
        return ref_regs[rs];
    endfunction

    task automatic apply_stimulus(input vec_t v, input logic [31:0] pc, input string tag);
        exp_t e;
        logic [31:0] ins;
        ins = v.instr;
        bus.de_instr     = v.instr;
        bus.de_pc        = pc;
        bus.de_pc_plus4  = pc + 32'd4;
        bus.ex_flush     = v.flush;
        bus.wb_reg_write = v.wb_we;
        bus.wb_rd        = v.wb_rd;
        bus.wb_result    = v.wb_data;
        e.imm = v.imm;  e.rd = v.rd;  e.rs1 = v.rs1;  e.rs2 = v.rs2;
        e.rw  = v.rw;   e.mw = v.mw;  e.br  = v.br;   e.jp  = v.jp;  e.jr = v.jr;
        e.res = v.res;  e.as = v.as;  e.bs  = v.bs;   e.alu = v.alu; e.f3 = v.f3;
        e.ill = v.ill;
        e.rd1 = v.flush ? 32'd0 : model_read(v.rs1, v);
        e.rd2 = v.flush ? 32'd0 : model_read(v.rs2, v);
        e.pc  = v.flush ? 32'd0 : pc;
        e.pc4 = v.flush ? 32'd0 : pc + 32'd4;
        sb.push_back(e);
        #1;
        chk(tag, "de_rs1", 32'(bus.de_rs1), 32'(ins[19:15]));
        chk(tag, "de_rs2", 32'(bus.de_rs2), 32'(ins[24:20]));
        @(posedge clk);
        if (v.wb_we && (v.wb_rd != 5'd0)) ref_regs[v.wb_rd] = v.wb_data;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            check_output(sb.pop_front(), tag);
        end
    endtask

    initial begin
        vec_t post;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        bus.de_instr = 32'd0; bus.de_pc = 32'd0; bus.de_pc_plus4 = 32'd0; bus.ex_flush = 1'b0;
        bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_result = 32'd0;
        rst_n = 1'b0;

        //          instr         fl    we    wbrd   wbdata         imm            rd     rs1    rs2    rw    mw    br    jp    jr    res    as     bs    alu    f3     ill
        vecs[0]  = '{32'h00500093, 1'b0, 1'b1, 5'd1,  32'h0000_1000, 32'h0000_0005, 5'd1,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[1]  = '{32'hFE20AE23, 1'b0, 1'b1, 5'd2,  32'hCAFE_F00D, 32'hFFFF_FFFC, 5'd28, 5'd1,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd2, 1'b0};
        vecs[2]  = '{32'h00318233, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 32'h0000_0003, 5'd4,  5'd3,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 1'b0};
        vecs[3]  = '{32'h00500093, 1'b0, 1'b1, 5'd0,  32'h1234_5678, 32'h0000_0005, 5'd1,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[4]  = '{32'hFE000CE3, 1'b0, 1'b0, 5'd0,  32'h0,         32'hFFFF_FFF8, 5'd25, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd1, 3'd0, 1'b0};
        vecs[5]  = '{32'h00500093, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 1'b0};
        vecs[6]  = '{32'h00000000, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 1'b1};
        vecs[7]  = '{32'h123452B7, 1'b0, 1'b0, 5'd0,  32'h0,         32'h1234_5000, 5'd5,  5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 4'd0, 3'd5, 1'b0};
        vecs[8]  = '{32'h008000EF, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0008, 5'd1,  5'd0,  5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[9]  = '{32'h00008067, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         5'd0,  5'd1,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[10] = '{32'h403182B3, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0403, 5'd5,  5'd3,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd1, 3'd0, 1'b0};
        vecs[11] = '{32'h4041D313, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0404, 5'd6,  5'd3,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4'd7, 3'd5, 1'b0};
        vecs[12] = '{32'h40018393, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0400, 5'd7,  5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[13] = '{32'h00C1A403, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_000C, 5'd8,  5'd3,  5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 4'd0, 3'd2, 1'b0};
        vecs[14] = '{32'hFFFFF497, 1'b0, 1'b1, 5'd31, 32'h55AA_55AA, 32'hFFFF_F000, 5'd9,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 4'd0, 3'd7, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_output(reset_expect(), "reset");
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i], 32'h0000_1000 + 32'(4 * i), $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a cycle, observed before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_output(reset_expect(), "async_reset");
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Registers written before reset must now read zero.
        post = vecs[2];
        post.wb_we = 1'b0;
        apply_stimulus(post, 32'h0000_2000, "post_reset_add");
        post = vecs[9];
        apply_stimulus(post, 32'h0000_2004, "post_reset_jalr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
